// File: rtl/ram8_bank16_if.sv
// Bus bundle for the eight-entry register bank: write/clear controls in,
// per-entry taps, addressed read, valid map and busy flag out.
interface ram8_bank16_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       address;
  logic             clr_req;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0]       valid;
  logic             busy;

  modport master (
    output in, load, address, clr_req,
    input  out, r0, r1, r2, r3, r4, r5, r6, r7, valid, busy
  );

  modport slave (
    input  in, load, address, clr_req,
    output out, r0, r1, r2, r3, r4, r5, r6, r7, valid, busy
  );
endinterface

// File: rtl/ram8_bank16.sv
// Eight-entry register bank with one write port and a background clear sequencer.
// Optional write-through on `out` when RAM8_WRITE_BYPASS_EN is defined.
module ram8_bank16 #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  ram8_bank16_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic             busy_q;
  logic [7:0]       valid_q;
  logic [WIDTH-1:0] mem [8];

  // NOTE: every entry is a flop with an explicit reset value, so the bank is
  // never X after reset; this rules out a RAM macro, which is fine at 8 entries.
  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // see pre-edge values of each other regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= '0;
      end
      valid_q <= 8'h00;
      state   <= IDLE;
      ptr     <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // A write in the same cycle as clr_req still lands; the sweep clears it later.
          if (bus.load) begin
            mem[bus.address]     <= bus.in;
            valid_q[bus.address] <= 1'b1;
          end
          if (bus.clr_req) begin
            state  <= CLEAR;
            ptr    <= 3'd0;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          mem[ptr]     <= CLR_VAL;
          valid_q[ptr] <= 1'b0;
          ptr          <= ptr + 3'd1;
          if (ptr == 3'd7) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RAM8_WRITE_BYPASS_EN
  // Write-through only when the write will actually be accepted.
  assign bus.out = (bus.load && !busy_q) ? bus.in : mem[bus.address];
`else
  assign bus.out = mem[bus.address];
`endif

  assign bus.r0    = mem[0];
  assign bus.r1    = mem[1];
  assign bus.r2    = mem[2];
  assign bus.r3    = mem[3];
  assign bus.r4    = mem[4];
  assign bus.r5    = mem[5];
  assign bus.r6    = mem[6];
  assign bus.r7    = mem[7];
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_ram8_bank16.sv
// Scoreboard bench for ram8_bank16: stimulus pushes expected outputs from an
// array-level model; a negedge monitor pops and compares against the DUT.
module tb_ram8_bank16;

  localparam logic [15:0] CLR = 16'h0000;

  typedef struct {
    logic [127:0] r;
    logic [7:0]   valid;
    logic         busy;
    logic [15:0]  out;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  ram8_bank16_if #(.WIDTH(16)) bus ();

  ram8_bank16 #(.WIDTH(16), .CLR_VAL(CLR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain array, valid map and a count of clear cycles remaining.
  logic [15:0] mem_m [8];
  logic [7:0]  valid_m;
  int          clr_left;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("r0..r7", {bus.r7, bus.r6, bus.r5, bus.r4, bus.r3, bus.r2, bus.r1, bus.r0}, e.r);
      check("valid", 128'(bus.valid), 128'(e.valid));
      check("busy", 128'(bus.busy), 128'(e.busy));
      check("out", 128'(bus.out), 128'(e.out));
    end
  end

  task automatic model_edge(input logic rv, input logic lv, input logic [2:0] av,
                            input logic [15:0] dv, input logic cv);
    if (!rv) begin
      for (int i = 0; i < 8; i++) mem_m[i] = 16'h0000;
      valid_m  = 8'h00;
      clr_left = 0;
    end else if (clr_left > 0) begin
      mem_m[8 - clr_left]   = CLR;
      valid_m[8 - clr_left] = 1'b0;
      clr_left--;
    end else begin
      if (lv) begin
        mem_m[av]   = dv;
        valid_m[av] = 1'b1;
      end
      if (cv) clr_left = 8;
    end
  endtask

  // One clock cycle: drive inputs, queue the expected view of this cycle, take the edge.
  task automatic step(input logic rv, input logic lv, input logic [2:0] av,
                      input logic [15:0] dv, input logic cv, input bit chk);
    exp_t e;
    rst_n       = rv;
    bus.load    = lv;
    bus.address = av;
    bus.in      = dv;
    bus.clr_req = cv;
    if (chk) begin
      for (int i = 0; i < 8; i++) e.r[i*16 +: 16] = mem_m[i];
      e.valid = valid_m;
      e.busy  = (clr_left > 0);
`ifdef RAM8_WRITE_BYPASS_EN
      e.out = (lv && clr_left == 0) ? dv : mem_m[av];
`else
      e.out = mem_m[av];
`endif
      sb.push_back(e);
    end
    @(posedge clk);
    model_edge(rv, lv, av, dv, cv);
    #1;
  endtask

  task automatic idle(input logic [2:0] av);
    step(1'b1, 1'b0, av, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic fill();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 3'(k), 16'(k) * 16'h1111, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.load    = 1'b0;
    bus.address = 3'd0;
    bus.in      = 16'h0000;
    bus.clr_req = 1'b0;
    for (int i = 0; i < 8; i++) mem_m[i] = 16'h0000;
    valid_m  = 8'h00;
    clr_left = 0;
    @(posedge clk);
    #1;

    // Reset held two clocks; storage is unknown before the first reset edge.
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b1, 1'b1);
    idle(3'd0);

    // Fill, then read back by address.
    fill();
    idle(3'd5);
    idle(3'd3);

    // Single-cycle clear pulse and the full sweep.
    step(1'b1, 1'b0, 3'd3, 16'h0000, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) idle(3'(c));

    // Writes and a second clr_req during CLEAR are ignored.
    fill();
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 1'b1, 3'd6, 16'hBEEF, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'd6, 16'h0000, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) idle(3'd6);

    // Write and clear on the same edge: the write lands, then gets swept.
    step(1'b1, 1'b1, 3'd7, 16'h1234, 1'b1, 1'b1);
    for (int c = 0; c < 9; c++) idle(3'd7);

    // Reset mid-clear aborts the sweep; a write right after succeeds.
    fill();
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) idle(3'd7);
    step(1'b0, 1'b0, 3'd7, 16'h0000, 1'b0, 1'b1);
    idle(3'd7);
    step(1'b1, 1'b1, 3'd4, 16'hCAFE, 1'b0, 1'b1);
    idle(3'd4);

    // Write over an existing value: out during the write cycle, r2 after the edge.
    step(1'b1, 1'b1, 3'd2, 16'h0042, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'd2, 16'hA5A5, 1'b0, 1'b1);
    idle(3'd2);

    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 400; n++) begin
      logic rv, lv, cv;
      rv = ($urandom_range(0, 63) != 0);
      lv = $urandom_range(0, 1) == 1;
      cv = ($urandom_range(0, 15) == 0);
      step(rv, lv, 3'($urandom_range(0, 7)), 16'($urandom), cv, 1'b1);
    end

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
